// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
// Write-side master for the 32x32 RV32I register file. Merges the single-cycle
// ALU result stream and the variable-latency load-return stream onto the one
// write port (Rd / Write_data / RegWrite). Load returns wait in a small FIFO and
// drain in idle ALU slots; a starvation counter forces a drain slot by stalling
// the ALU for one cycle. A scoreboard query reports registers with a pending
// (FIFO) or in-flight (output register) write so decode can avoid hazards.
//
// Optional feature macro: WB_FWD_EN
//   When defined, adds fwd_hit1/fwd_hit2 and fwd_data1/fwd_data2 so decode can
//   bypass the register file's read-before-write window on the in-flight write.
//   When undefined, those ports and their logic are absent.
module regfile_writeback_arbiter #(
    parameter int DEPTH      = 4,   // load-return FIFO entries, power of 2, >= 2
    parameter int STARVE_MAX = 8    // non-draining cycles tolerated before alu_stall
) (
    input  logic        clk,
    input  logic        reset,
    // ALU result stream
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    // load-return stream
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    // register file write port
    output logic [4:0]  Rd,
    output logic [31:0] Write_data,
    output logic        RegWrite,
    // scoreboard query
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        chk_busy1,
    output logic        chk_busy2
`ifdef WB_FWD_EN
    ,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX - 1);

    // FIFO state: pointers carry one extra bit to tell full from empty
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [4:0]     r_fifo_rd   [DEPTH];
    logic [31:0]    r_fifo_data [DEPTH];

    // starvation tracking and registered stall
    logic [SW-1:0]  r_starve;
    logic           r_stall;

    // write-port output registers
    logic           r_we;
    logic [4:0]     r_rd;
    logic [31:0]    r_wdata;

    // combinational control
    logic [AW:0]    w_count;
    logic           w_empty;
    logic           w_full;
    logic           w_ld_ready;
    logic           w_push;
    logic           w_grant_alu;
    logic           w_pop;
    logic [SW-1:0]  w_starve_nxt;
    logic [AW-1:0]  w_head_idx;
    logic [AW-1:0]  w_tail_idx;
    logic [AW-1:0]  w_scan_idx;
    logic           w_busy1;
    logic           w_busy2;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head_idx = r_rd_ptr[AW-1:0];
    assign w_tail_idx = r_wr_ptr[AW-1:0];

    // ready depends only on registered occupancy; a same-cycle pop gives no credit
    assign w_ld_ready = ~w_full & ~reset;

    // x0 loads complete the handshake but are never stored
    assign w_push     = ld_valid & w_ld_ready & (ld_rd != 5'd0);

    // ALU wins the slot unless stalled or writing x0; otherwise the FIFO head drains
    assign w_grant_alu = ~r_stall & alu_valid & (alu_rd != 5'd0);
    assign w_pop       = ~w_grant_alu & ~w_empty;

    // counter tracks consecutive cycles with waiting loads that did not drain
    assign w_starve_nxt = (w_empty || w_pop) ? '0 : (r_starve + 1'b1);

    // --- stage boundary: arbitration -> registered write port ---

    // FIFO pointers, starvation counter, stall and write-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_we     <= 1'b0;
            r_rd     <= 5'd0;
            r_wdata  <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_starve <= w_starve_nxt;
            // the stalled cycle is the one in which the counter sits at its limit
            r_stall  <= ~w_empty && (w_starve_nxt == STARVE_LIMIT);
            if (w_grant_alu) begin
                r_we    <= 1'b1;
                r_rd    <= alu_rd;
                r_wdata <= alu_data;
            end else if (w_pop) begin
                r_we    <= 1'b1;
                r_rd    <= r_fifo_rd[w_head_idx];
                r_wdata <= r_fifo_data[w_head_idx];
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    // FIFO payload storage; validity is defined by the pointers alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[w_tail_idx]   <= ld_rd;
            r_fifo_data[w_tail_idx] <= ld_data;
        end
    end

    // scoreboard: scan only the occupied FIFO slots plus the in-flight write
    always_comb begin
        w_busy1    = 1'b0;
        w_busy2    = 1'b0;
        w_scan_idx = w_head_idx;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = w_head_idx + AW'(k);
            if ((AW+1)'(k) < w_count) begin
                if (r_fifo_rd[w_scan_idx] == chk_rs1) begin
                    w_busy1 = 1'b1;
                end
                if (r_fifo_rd[w_scan_idx] == chk_rs2) begin
                    w_busy2 = 1'b1;
                end
            end
        end
        if (r_we && (r_rd == chk_rs1)) begin
            w_busy1 = 1'b1;
        end
        if (r_we && (r_rd == chk_rs2)) begin
            w_busy2 = 1'b1;
        end
        // x0 is never a hazard
        if (chk_rs1 == 5'd0) begin
            w_busy1 = 1'b0;
        end
        if (chk_rs2 == 5'd0) begin
            w_busy2 = 1'b0;
        end
    end

    assign ld_ready   = w_ld_ready;
    assign alu_stall  = r_stall;
    assign RegWrite   = r_we;
    assign Rd         = r_rd;
    assign Write_data = r_wdata;
    assign chk_busy1  = w_busy1;
    assign chk_busy2  = w_busy2;

`ifdef WB_FWD_EN
    // bypass the value being written this cycle to a matching decode read
    assign fwd_hit1  = r_we & (r_rd != 5'd0) & (r_rd == chk_rs1);
    assign fwd_hit2  = r_we & (r_rd != 5'd0) & (r_rd == chk_rs2);
    assign fwd_data1 = fwd_hit1 ? r_wdata : 32'd0;
    assign fwd_data2 = fwd_hit2 ? r_wdata : 32'd0;
`endif

endmodule
